irq_vector_ctrl: RTL
====================

# irq_vector_ctrl

Parametrised, vectored interrupt controller replacing the single-source external interrupt handler in the 5-stage RISC-V pipeline. Synchronises NUM_SRC asynchronous interrupt lines, latches edge events, arbitrates by fixed priority (lowest index wins), and presents one request at a time to the hazard/fetch logic with a per-source handler address. A request/acknowledge/done handshake with the pipeline ensures exactly one interrupt is in service at a time (no nesting).

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..32
- SYNC_STAGES, 2: synchroniser flops per source, ≥2
- EDGE_MODE, all ones: per-source bitmask (NUM_SRC bits); 1 = rising-edge latched, 0 = level
- BASE_ADDR, 32'h0000_0100: handler address of source 0
- VEC_STRIDE, 4: byte distance between consecutive handler entries
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ext_irq  in  NUM_SRC  raw asynchronous interrupt lines
- irq_enable  in  NUM_SRC  per-source mask, 1 = enabled (synchronous to clk)
- global_en  in  1  pipeline may accept a new interrupt (from hazard unit)
- irq_ack  in  1  one-cycle pulse: pipeline has redirected PC to handler_addr
- irq_done  in  1  one-cycle pulse: handler returned (mret retired)
- irq_take  out  1  interrupt request to hazard/fetch (interrupt_ctrl)
- irq_id  out  max(1,$clog2(NUM_SRC))  index of requested/in-service source
- handler_addr  out  32  BASE_ADDR + irq_id*VEC_STRIDE
- in_service  out  1  handler currently executing
- pending  out  NUM_SRC  current pending vector (before masking)

## Operation
- Synchroniser: each ext_irq bit passes through SYNC_STAGES flops; sync_d holds the previous synchronised value.
- Edge sources (EDGE_MODE[i]=1): pending[i] set on sync & ~sync_d; cleared on irq_ack when irq_id==i. Set and clear in the same cycle for the same bit: set wins (new event kept).
- Level sources: pending[i] = synchronised level; never latched; irq_ack has no effect on it.
- Pending bits accumulate regardless of irq_enable, global_en or state; masking applies only to arbitration.
- Candidates = pending & irq_enable; winner = lowest set index.
- FSM:
  - IDLE: if global_en and candidates≠0 → REQ; irq_id/handler_addr registered from winner.
  - REQ: irq_take=1; irq_id, handler_addr frozen; request is never withdrawn (mask change, level drop or global_en drop ignored). irq_ack → SERVICE, clears the edge pending bit.
  - SERVICE: in_service=1, irq_take=0; new events only set pending. irq_done → IDLE.
- irq_ack outside REQ and irq_done outside SERVICE are ignored.
- handler_addr arithmetic: 32-bit, wraps modulo 2^32.
- Reset (async): state IDLE, sync chain, sync_d and pending all 0, irq_take=0, in_service=0, irq_id=0, handler_addr=BASE_ADDR. Reset mid-REQ/SERVICE drops the request immediately; events in flight are lost.

## Timing
- All outputs registered; no combinational input→output path.
- Edge source, SYNC_STAGES=2: ext_irq high sampled at edge 0 → pending[i] high after edge 2 → irq_take high after edge 3 (if IDLE, enabled, global_en).
- irq_ack sampled at edge n → irq_take low, in_service high, pending bit cleared after edge n.
- irq_done sampled at edge m → IDLE after edge m; next request earliest after edge m+1 (one dead cycle minimum between in_service falling and irq_take rising).
- Pulse on ext_irq shorter than one clk period may be missed; sources must hold ≥2 clk cycles.

## Test plan
- Single edge: NUM_SRC=8, enable=0xFF, global_en=1, ext_irq[3] rises at edge 0 → pending=0x08 after edge 2, irq_take=1, irq_id=3, handler_addr=0x10C after edge 3; ack → pending=0x00, in_service=1.
- Priority: ext_irq[5] and [2] rise same cycle → irq_id=2, addr 0x108; after ack+done, second request irq_id=5, addr 0x114 exactly two cycles after done.
- Masking/hold: enable=0xF7, ext_irq[3] rises → pending[3]=1, no irq_take; set enable[3]=1 → irq_take next cycle; clearing enable[3] while in REQ keeps irq_take=1 until ack.
- No nesting: during SERVICE for id 4, ext_irq[0] rises → pending[0]=1, irq_take stays 0; on irq_done → irq_id=0 requested after one dead cycle.
- Level source: EDGE_MODE bit 1=0, hold ext_irq[1] high → after ack+done, re-requested id 1; drop line → pending[1]=0, no request.
- Reset/corners: assert rst mid-SERVICE → all outputs reset immediately, handler_addr=0x100; same-cycle new edge and ack on id 6 → pending[6] stays 1; stray irq_ack/irq_done in IDLE → no state change.

Source files
------------

// File: rtl/irq_vector_ctrl.sv
// -----------------------------------------------------------------------------
// irq_vector_ctrl
//
// Vectored interrupt controller for the 5-stage pipeline. Synchronises
// NUM_SRC asynchronous interrupt lines and latches rising edges on edge-mode
// sources. Level-mode sources follow their synchronised line. The lowest
// enabled pending index wins arbitration. One request at a time goes to the
// hazard/fetch logic through a req/ack/done handshake, so interrupts never
// nest.
//
// Parameters
//   NUM_SRC      number of interrupt sources (1..32)
//   SYNC_STAGES  synchroniser depth per source (>= 2)
//   EDGE_MODE    per-source: 1 = rising-edge latched, 0 = level
//   BASE_ADDR    handler address of source 0
//   VEC_STRIDE   byte distance between consecutive handler entries
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   ext_irq       raw asynchronous interrupt lines
//   irq_enable    per-source arbitration mask (1 = enabled)
//   global_en     pipeline may accept a new interrupt
//   irq_ack       pulse: pipeline redirected PC to handler_addr
//   irq_done      pulse: handler returned (mret retired)
//   irq_take      interrupt request to hazard/fetch
//   irq_id        index of the requested / in-service source
//   handler_addr  BASE_ADDR + irq_id * VEC_STRIDE (mod 2^32)
//   in_service    handler currently executing
//   pending       pending vector before masking
// -----------------------------------------------------------------------------
module irq_vector_ctrl #(
  parameter int unsigned        NUM_SRC     = 8,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MODE   = '1,
  parameter logic [31:0]        BASE_ADDR   = 32'h0000_0100,
  parameter logic [31:0]        VEC_STRIDE  = 32'd4,
  localparam int unsigned       ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ext_irq,
  input  logic [NUM_SRC-1:0] irq_enable,
  input  logic               global_en,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_take,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        handler_addr,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_t;

  state_t state;

  logic [NUM_SRC-1:0] sync_chain [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_d;
  logic [NUM_SRC-1:0] sync_now;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] candidates;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    win_id;
  logic               ack_fire;

  // ---------------------------------------------------------------------------
  // Synchroniser and previous-value register used for edge detection.
  // ---------------------------------------------------------------------------
  // NOTE: this array is reset explicitly. Every flop in the chain must come up
  // at 0, or a stale 1 would show up as a phantom edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_chain[s] <= '0;
      sync_d <= '0;
    end else begin
      sync_chain[0] <= ext_irq;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_chain[s] <= sync_chain[s-1];
      sync_d <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign sync_now   = sync_chain[SYNC_STAGES-1];
  assign rise       = sync_now & ~sync_d;
  assign candidates = pending & irq_enable;
  assign ack_fire   = (state == S_REQ) && irq_ack;

  // Fixed priority: scan from the top so the lowest set index is written last.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    win_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (candidates[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ack_clr[i] = ack_fire && (irq_id == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Pending vector. Edge bits latch until acked; a new edge in the ack cycle
  // wins over the clear so the event is not lost. Level bits track the line.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (EDGE_MODE[i]) pending[i] <= rise[i] | (pending[i] & ~ack_clr[i]);
        else              pending[i] <= sync_now[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered outputs. Once raised, a request is held
  // until acked, whatever happens to the mask, the line or global_en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      irq_take     <= 1'b0;
      in_service   <= 1'b0;
      irq_id       <= '0;
      handler_addr <= BASE_ADDR;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (global_en && (candidates != '0)) begin
            state        <= S_REQ;
            irq_take     <= 1'b1;
            irq_id       <= win_id;
            handler_addr <= BASE_ADDR + 32'(win_id) * VEC_STRIDE;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            state      <= S_SERVICE;
            irq_take   <= 1'b0;
            in_service <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (irq_done) begin
            state      <= S_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          irq_take   <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
